config_table_tx: RTL and testbench
==================================

// Module: config_table_tx
// PURPOSE
// - Transmit side for package-defined configuration constants: holds a table of ENTRIES words,
//   reset-loaded from RESET_VALUE, and streams them out as (index, data) over valid/ready.
// - Sits beside the modules that consume package constants and lets a downstream receiver
//   rebuild the same table at runtime. Host writes may update entries between or during bursts.
// PARAMETERS
// - ENTRIES      4   number of table words, >= 1
// - WIDTH       10   data width of each word, >= 1
// - RESET_VALUE  0   reset value of every entry, zero-extended or truncated to WIDTH
// - IDXW  $clog2(ENTRIES) with a minimum of 1. Derived localparam, not overridable.
// PORTS
// - i_clk      input   1      clock; all logic samples on the rising edge
// - i_rst      input   1      reset, asynchronous, active-low
// - i_start    input   1      request a burst of all entries, 0..ENTRIES-1
// - i_wr_en    input   1      table write strobe
// - i_wr_idx   input   IDXW   table write index
// - i_wr_data  input   WIDTH  table write data
// - o_valid    output  1      (o_index, o_data) is presented
// - o_index    output  IDXW   index of the presented word
// - o_data     output  WIDTH  presented word
// - i_ready    input   1      receiver accepts the word; a handshake is o_valid & i_ready
// - o_busy     output  1      high in SEND or DONE
// - o_done     output  1      one-cycle pulse after the last handshake
// BEHAVIOUR
// - Reset (i_rst=0, asynchronous): table = RESET_VALUE; state = IDLE; o_valid=0, o_index=0,
//   o_data=0, o_busy=0, o_done=0. Every output is a register.
// - FSM IDLE -> SEND -> DONE -> IDLE.
//   - IDLE: i_start=1 -> SEND on the next cycle with o_valid=1, o_index=0, o_data=table[0].
//     Latency from i_start to first o_valid is 1 cycle.
//   - SEND: o_index and o_data stay stable while o_valid=1 and i_ready=0.
//   - SEND, handshake with o_index<ENTRIES-1: next cycle o_index+1 and o_data=table[o_index+1].
//     No bubble, so full throughput is 1 word/cycle.
//   - SEND, handshake with o_index==ENTRIES-1: next cycle o_valid=0, state DONE, o_done=1.
//   - DONE: exactly one cycle, then IDLE with o_done=0 and o_busy=0.
//   - i_start outside IDLE is ignored; it is not queued.
// - ENTRIES=1: a burst is one word. The first handshake goes directly to DONE.
// - Writes are accepted in any state:
//   table[i_wr_idx] <= i_wr_data when i_wr_en=1 and i_wr_idx<ENTRIES; out-of-range writes are dropped.
// - o_data is a snapshot taken when a word is loaded. A write to the presented index does not
//   change o_data until that word is reloaded in a later burst.
// - Bypass: if a write hits the index being loaded on the same edge, the loaded word is i_wr_data.
//   This covers i_start in IDLE with a write to index 0, and a handshake with a write to o_index+1.
// - Same-index writes can occur in one cycle only through a single port, so there is no write
//   conflict. The last write before a load wins.
// - If reset is asserted mid-burst, the burst is aborted immediately and o_done does not pulse.
//   The table reverts to RESET_VALUE.
// - There is no arithmetic beyond the index increment, which never wraps: the FSM exits at ENTRIES-1.
// TESTING
// - Reset then i_start with i_ready=1 -> words (0,0),(1,0),(2,0),(3,0) on consecutive cycles;
//   o_done pulses on cycle 5; o_busy is high on cycles 1-5.
// - Write idx2=0x155 in IDLE, then burst with i_ready toggling 1,0,1,0 -> each word is held
//   while ready=0, and index 2 carries 0x155.
// - During SEND at index 1 with ready=0, write idx1=0x3FF -> o_data stays at the old value.
//   A second burst shows 0x3FF.
// - Handshake at index 0 on the same edge as a write of 0x2AA to idx1 -> the next word is
//   (1, 0x2AA). The bypass is checked.
// - Pulse i_start during SEND and DONE -> ignored: exactly 4 handshakes and one o_done per burst.
// - Assert i_rst mid-burst at index 2 -> outputs are 0 at once with no o_done;
//   after release the table reads back RESET_VALUE.

Source files
------------

// File: rtl/config_table_tx.sv
// Configuration table transmitter: a reset-loaded table of ENTRIES words that is streamed out
// as (index, data) over valid/ready on request, while host writes may update it at any time.
module config_table_tx #(
  parameter int unsigned ENTRIES     = 4,
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned RESET_VALUE = 0,
  localparam int unsigned IDXW       = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_wr_en,
  input  logic [IDXW-1:0]  i_wr_idx,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_valid,
  output logic [IDXW-1:0]  o_index,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] RstWord = WIDTH'(RESET_VALUE);
  localparam logic [IDXW-1:0]  LastIdx = IDXW'(ENTRIES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

  state_e           r_state;
  logic             r_valid;
  logic [IDXW-1:0]  r_index;
  logic [WIDTH-1:0] r_data;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_table [ENTRIES];

  logic             w_wr_hit;
  logic             w_last;
  logic             w_hs;
  logic [IDXW-1:0]  w_load_idx;
  logic [WIDTH-1:0] w_load_data;

  always_comb begin
    w_wr_hit   = i_wr_en && (32'(i_wr_idx) < ENTRIES);
    w_last     = (r_index == LastIdx);
    w_hs       = r_valid & i_ready;
    // Index of the word loaded on this edge: 0 when starting, else the successor.
    w_load_idx = ((r_state == StSend) && !w_last) ? r_index + IDXW'(1) : '0;
    w_load_data = r_table[w_load_idx];
    // Same-edge write to the loaded index bypasses the table.
    if (w_wr_hit && (i_wr_idx == w_load_idx)) begin
      w_load_data = i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_table[i] <= RstWord;
      end
    end else if (w_wr_hit) begin
      r_table[i_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= StIdle;
      r_valid <= 1'b0;
      r_index <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StSend;
            r_valid <= 1'b1;
            r_index <= '0;
            r_data  <= w_load_data;
            r_busy  <= 1'b1;
          end
        end
        StSend: begin
          if (w_hs) begin
            if (w_last) begin
              r_state <= StDone;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_index <= w_load_idx;
              r_data  <= w_load_data;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_index = r_index;
  assign o_data  = r_data;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_config_table_tx.sv
// Bench for config_table_tx: scoreboard of expected (index, data) words checked at each
// handshake, table-driven bursts, and hand-written reset/timing sequences.
module tb_config_table_tx;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic       i_wr_en;
  logic [1:0] i_wr_idx;
  logic [9:0] i_wr_data;
  logic       o_valid;
  logic [1:0] o_index;
  logic [9:0] o_data;
  logic       i_ready;
  logic       o_busy;
  logic       o_done;

  int n_cmp = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  logic [11:0] sb_q[$];

  logic       hold_v = 1'b0;
  logic [1:0] hold_idx;
  logic [9:0] hold_data;

  typedef struct {
    logic [7:0]       pat;      // ready per cycle after start, bit 0 first, repeating
    int               wr_cyc;   // -1: before start, 0: with start, n: n cycles later, -2: none
    logic [1:0]       wr_idx;
    logic [9:0]       wr_data;
    bit               restart;  // keep i_start high through SEND and DONE
    logic [3:0][9:0]  exp;      // {w3, w2, w1, w0}
  } vec_t;

  vec_t vecs[9];

  config_table_tx #(
    .ENTRIES    (4),
    .WIDTH      (10),
    .RESET_VALUE(0)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_wr_en  (i_wr_en),
    .i_wr_idx (i_wr_idx),
    .i_wr_data(i_wr_data),
    .o_valid  (o_valid),
    .o_index  (o_index),
    .o_data   (o_data),
    .i_ready  (i_ready),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshake monitor: pops the scoreboard and checks hold stability under backpressure.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 32'(o_valid), 32'(1));
        check("hold_index", 32'(o_index), 32'(hold_idx));
        check("hold_data", 32'(o_data), 32'(hold_data));
      end
      if (o_valid && i_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got (%0d, 0x%0h), expected none", o_index, o_data);
        end else begin
          logic [11:0] e;
          e = sb_q.pop_front();
          check("word_index", 32'(o_index), 32'(e[11:10]));
          check("word_data", 32'(o_data), 32'(e[9:0]));
        end
      end
      if (o_done) done_cnt++;
      hold_v    = o_valid && !i_ready;
      hold_idx  = o_index;
      hold_data = o_data;
    end
  end

  task automatic push_words(input logic [3:0][9:0] w);
    for (int k = 0; k < 4; k++) sb_q.push_back({2'(k), w[k]});
  endtask

  task automatic burst(input vec_t v);
    bit seen;
    int hs0;
    int d0;
    hs0 = hs_cnt;
    d0  = done_cnt;
    i_start   = 1'b0;
    i_ready   = 1'b0;
    i_wr_idx  = v.wr_idx;
    i_wr_data = v.wr_data;
    i_wr_en   = (v.wr_cyc == -1);
    @(posedge i_clk); #1;
    push_words(v.exp);
    seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      i_start = (c == 0) || v.restart;
      i_ready = (c == 0) ? 1'b0 : v.pat[(c - 1) % 8];
      i_wr_en = (v.wr_cyc == c);
      @(negedge i_clk);
      seen = o_done;
      @(posedge i_clk); #1;
    end
    i_start = 1'b0;
    i_wr_en = 1'b0;
    i_ready = 1'b0;
    check("done_seen", 32'(seen), 32'(1));
    @(negedge i_clk);
    check("idle_busy", 32'(o_busy), 32'(0));
    check("idle_valid", 32'(o_valid), 32'(0));
    check("handshakes", 32'(hs_cnt - hs0), 32'(4));
    check("done_pulses", 32'(done_cnt - d0), 32'(1));
    check("sb_drained", 32'(sb_q.size()), 32'(0));
    sb_q.delete();
    @(posedge i_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t zero_v;
    int d0;

    vecs[0] = '{pat: 8'hFF, wr_cyc: -2, wr_idx: 2'd0, wr_data: 10'h000, restart: 1'b0,
                exp: {10'h000, 10'h000, 10'h000, 10'h000}};
    vecs[1] = '{pat: 8'h55, wr_cyc: -1, wr_idx: 2'd2, wr_data: 10'h155, restart: 1'b0,
                exp: {10'h000, 10'h155, 10'h000, 10'h000}};
    // Write to the presented index while held: the snapshot keeps the old word.
    vecs[2] = '{pat: 8'hF9, wr_cyc: 2, wr_idx: 2'd1, wr_data: 10'h3FF, restart: 1'b0,
                exp: {10'h000, 10'h155, 10'h000, 10'h000}};
    vecs[3] = '{pat: 8'hFF, wr_cyc: -2, wr_idx: 2'd0, wr_data: 10'h000, restart: 1'b0,
                exp: {10'h000, 10'h155, 10'h3FF, 10'h000}};
    vecs[4] = '{pat: 8'hFF, wr_cyc: 1, wr_idx: 2'd1, wr_data: 10'h2AA, restart: 1'b0,
                exp: {10'h000, 10'h155, 10'h2AA, 10'h000}};
    vecs[5] = '{pat: 8'hFF, wr_cyc: 0, wr_idx: 2'd0, wr_data: 10'h0AB, restart: 1'b0,
                exp: {10'h000, 10'h155, 10'h2AA, 10'h0AB}};
    vecs[6] = '{pat: 8'h33, wr_cyc: -2, wr_idx: 2'd0, wr_data: 10'h000, restart: 1'b1,
                exp: {10'h000, 10'h155, 10'h2AA, 10'h0AB}};
    vecs[7] = '{pat: 8'hEE, wr_cyc: -1, wr_idx: 2'd3, wr_data: 10'h3C3, restart: 1'b0,
                exp: {10'h3C3, 10'h155, 10'h2AA, 10'h0AB}};
    // Write to a not-yet-loaded index mid-burst shows up in the same burst.
    vecs[8] = '{pat: 8'hFF, wr_cyc: 2, wr_idx: 2'd3, wr_data: 10'h111, restart: 1'b0,
                exp: {10'h111, 10'h155, 10'h2AA, 10'h0AB}};
    zero_v  = vecs[0];

    i_rst = 1'b0;
    i_start = 1'b0;
    i_wr_en = 1'b0;
    i_wr_idx = 2'd0;
    i_wr_data = 10'h000;
    i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_valid", 32'(o_valid), 32'(0));
    check("rst_index", 32'(o_index), 32'(0));
    check("rst_data", 32'(o_data), 32'(0));
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_done", 32'(o_done), 32'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // Cycle-accurate first burst: start on cycle 0, words on 1-4, done on 5.
    push_words({10'h000, 10'h000, 10'h000, 10'h000});
    d0 = done_cnt;
    i_start = 1'b1;
    i_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      @(negedge i_clk);
      check("t_busy", 32'(o_busy), 32'(c <= 5));
      check("t_valid", 32'(o_valid), 32'(c <= 4));
      check("t_done", 32'(o_done), 32'(c == 5));
      if (c <= 4) check("t_index", 32'(o_index), 32'(c - 1));
    end
    check("t_done_count", 32'(done_cnt - d0), 32'(1));
    check("t_sb_drained", 32'(sb_q.size()), 32'(0));
    i_ready = 1'b0;
    @(posedge i_clk); #1;

    for (int i = 0; i < 9; i++) burst(vecs[i]);

    // Reset mid-burst while index 2 is held.
    push_words(vecs[8].exp);
    d0 = done_cnt;
    i_start = 1'b1;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    check("mid_index_before", 32'(o_index), 32'(2));
    check("mid_valid_before", 32'(o_valid), 32'(1));
    #2;
    i_rst = 1'b0;
    #1;
    check("mid_valid", 32'(o_valid), 32'(0));
    check("mid_index", 32'(o_index), 32'(0));
    check("mid_data", 32'(o_data), 32'(0));
    check("mid_busy", 32'(o_busy), 32'(0));
    check("mid_done", 32'(o_done), 32'(0));
    sb_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    check("mid_no_done", 32'(done_cnt - d0), 32'(0));
    @(posedge i_clk); #1;
    burst(zero_v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
